// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================
// Module   : mem_wb_stage_pkg
// Purpose  : Shared encodings for the Memory-to-Writeback stage
// Revision : 1.0
// ============================================================
package mem_wb_stage_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC  = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_result_mux.sv
`default_nettype none
// ============================================================
// Module   : wb_result_mux
// Purpose  : 3:1 writeback result select (ALU / load data / PC+1)
// Revision : 1.0
// ============================================================
module wb_result_mux
  import mem_wb_stage_pkg::*;
#(
  parameter int M = 32
) (
  input  logic [1:0]   sel,
  input  logic         load_done,
  input  logic [M-1:0] alu,
  input  logic [M-1:0] rdata,
  input  logic [M-1:0] pcplus,
  output logic [M-1:0] result
);

  always_comb begin
    result = alu;
    case (sel)
      // Load data only exists for a genuine read; stores fall back to the ALU value.
      RES_MEM: if (load_done) result = rdata;
      RES_PC:  result = pcplus;
      default: result = alu;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================
// Module   : mem_wb_stage
// Purpose  : Memory stage data-memory handshake with timeout, feeding the W register
// Revision : 1.0
// ============================================================
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int M       = 32,
  parameter int N       = 5,
  parameter int TIMEOUT = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [M-1:0] aluM,
  input  logic [M-1:0] writeDM,
  input  logic [N-1:0] writeRM,
  input  logic [M-1:0] pcplusM,
  input  logic         memreadM,
  input  logic         memwriteM,
  input  logic         regwriteM,
  input  logic [1:0]   resultsrcM,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [M-1:0] dmem_addr,
  output logic [M-1:0] dmem_wdata,
  input  logic [M-1:0] dmem_rdata,
  input  logic         dmem_ready,
  output logic         stallM,
  output logic [M-1:0] resultW,
  output logic [N-1:0] writeRW,
  output logic         regwriteW,
  output logic         memerrW
);

  localparam int CW = $clog2(TIMEOUT);

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic            memop;
  logic            illegal;
  logic            timeout_hit;
  logic            do_capture;
  logic            regwrite_next;
  logic [M-1:0]    result_sel;

  assign memop         = memreadM | memwriteM;
  assign illegal       = memreadM & memwriteM;
  assign timeout_hit   = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT - 1)) && !dmem_ready;
  assign regwrite_next = regwriteM & (writeRM != '0) & ~illegal;

  assign dmem_req   = (state == S_WAIT) | memop;
  assign dmem_we    = memwriteM;
  assign dmem_addr  = aluM;
  assign dmem_wdata = writeDM;

  // The abort cycle releases the stall so upstream can move on.
  assign stallM = (state == S_WAIT) ? (~dmem_ready & ~timeout_hit)
                                    : (memop & ~dmem_ready);

  assign do_capture = (state == S_WAIT) ? dmem_ready : ~stallM;

  wb_result_mux #(.M(M)) u_result_mux (
    .sel       (resultsrcM),
    .load_done (memreadM & ~memwriteM),
    .alu       (aluM),
    .rdata     (dmem_rdata),
    .pcplus    (pcplusM),
    .result    (result_sel)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      resultW   <= '0;
      writeRW   <= '0;
      regwriteW <= 1'b0;
      memerrW   <= 1'b0;
    end else begin
      regwriteW <= 1'b0;
      if (do_capture) begin
        resultW   <= result_sel;
        writeRW   <= writeRM;
        regwriteW <= regwrite_next;
        if (illegal) memerrW <= 1'b1;
      end
      if (timeout_hit) memerrW <= 1'b1;

      case (state)
        S_IDLE: begin
          if (memop && !dmem_ready) begin
            state    <= S_WAIT;
            wait_cnt <= CW'(1);
          end
        end
        S_WAIT: begin
          if (dmem_ready || timeout_hit) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage against a cycle-level reference model
// Revision : 1.0
// ============================================================
module tb_mem_wb_stage;

  localparam int M       = 32;
  localparam int N       = 5;
  localparam int TIMEOUT = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [M-1:0] aluM, writeDM, pcplusM, dmem_rdata;
  logic [N-1:0] writeRM;
  logic         memreadM, memwriteM, regwriteM, dmem_ready;
  logic [1:0]   resultsrcM;
  logic         dmem_req, dmem_we, stallM, regwriteW, memerrW;
  logic [M-1:0] dmem_addr, dmem_wdata, resultW;
  logic [N-1:0] writeRW;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [M-1:0] m_result;
  logic [N-1:0] m_wr;
  logic         m_rw;
  logic         m_err;
  int           waited;
  logic         m_last_stall;

  mem_wb_stage #(.M(M), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .aluM       (aluM),
    .writeDM    (writeDM),
    .writeRM    (writeRM),
    .pcplusM    (pcplusM),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .regwriteM  (regwriteM),
    .resultsrcM (resultsrcM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .stallM     (stallM),
    .resultW    (resultW),
    .writeRW    (writeRW),
    .regwriteW  (regwriteW),
    .memerrW    (memerrW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic rw, input logic [1:0] sel,
                        input logic [M-1:0] alu, input logic [M-1:0] wd,
                        input logic [M-1:0] pc, input logic [N-1:0] reg_idx);
    memreadM = rd; memwriteM = wr; regwriteM = rw; resultsrcM = sel;
    aluM = alu; writeDM = wd; pcplusM = pc; writeRM = reg_idx;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model at the edge, check W after.
  task automatic step();
    logic memop, ill, exp_stall;
    logic [M-1:0] res;
    memop     = memreadM | memwriteM;
    ill       = memreadM & memwriteM;
    exp_stall = memop && !dmem_ready && (waited < TIMEOUT - 1);
    #3;
    if (!RST) begin
      chk("dmem_req",   dmem_req,   memop || (waited > 0));
      chk("dmem_we",    dmem_we,    memwriteM);
      chk("dmem_addr",  dmem_addr,  aluM);
      chk("dmem_wdata", dmem_wdata, writeDM);
      chk("stallM",     stallM,     exp_stall);
    end
    @(posedge CLK);
    if (RST) begin
      m_result = '0; m_wr = '0; m_rw = 1'b0; m_err = 1'b0; waited = 0; exp_stall = 1'b0;
    end else if (exp_stall) begin
      m_rw = 1'b0;
      waited++;
    end else if (memop && !dmem_ready) begin
      m_err = 1'b1; m_rw = 1'b0; waited = 0;
    end else begin
      if (resultsrcM == 2'b01)      res = (memreadM && !memwriteM) ? dmem_rdata : aluM;
      else if (resultsrcM == 2'b10) res = pcplusM;
      else                          res = aluM;
      m_result = res;
      m_wr     = writeRM;
      m_rw     = regwriteM && (writeRM != 0) && !ill;
      if (ill) m_err = 1'b1;
      waited = 0;
    end
    m_last_stall = exp_stall;
    #1;
    chk("resultW",   resultW,   m_result);
    chk("writeRW",   writeRW,   m_wr);
    chk("regwriteW", regwriteW, m_rw);
    chk("memerrW",   memerrW,   m_err);
  endtask

  initial begin
    m_result = '0; m_wr = '0; m_rw = 1'b0; m_err = 1'b0; waited = 0; m_last_stall = 1'b0;

    // Reset with garbage inputs
    RST = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    set_op(1'b1, 1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'h1234_5678, 32'h9, 5'd31);
    @(posedge CLK); #1;
    step();
    step();
    RST = 1'b0; dmem_ready = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    #3;
    chk("reset_dmem_req", dmem_req, 1'b0);
    @(posedge CLK); #1;

    // Non-memory op
    set_op(1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0014, 32'h0, 32'h0, 5'd3);
    step();
    chk("alu_result_value", resultW, 32'h14);

    // Zero-wait load
    set_op(1'b1, 1'b0, 1'b1, 2'b01, 32'h40, 32'h0, 32'h0, 5'd7);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    chk("zero_wait_load_value", resultW, 32'hDEAD_BEEF);

    // Store with three wait cycles
    set_op(1'b0, 1'b1, 1'b0, 2'b00, 32'h80, 32'h55, 32'h0, 5'd0);
    dmem_ready = 1'b0;
    repeat (3) step();
    dmem_ready = 1'b1;
    step();
    chk("store_done_no_stall", m_last_stall, 1'b0);

    // Load that never completes: abort after TIMEOUT cycles
    set_op(1'b1, 1'b0, 1'b1, 2'b01, 32'h44, 32'h0, 32'h0, 5'd9);
    dmem_ready = 1'b0;
    repeat (TIMEOUT) step();
    chk("timeout_memerr", memerrW, 1'b1);
    set_op(1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0ABC, 32'h0, 32'h0, 5'd4);
    step();
    chk("after_timeout_regwrite", regwriteW, 1'b1);

    // jal-style op targeting x0
    set_op(1'b0, 1'b0, 1'b1, 2'b10, 32'h77, 32'h0, 32'h21, 5'd0);
    step();
    chk("jal_result", resultW, 32'h21);

    // Illegal read+write
    set_op(1'b1, 1'b1, 1'b1, 2'b01, 32'h90, 32'h5, 32'h0, 5'd6);
    dmem_ready = 1'b1;
    step();

    // Reset while waiting
    set_op(1'b1, 1'b0, 1'b1, 2'b01, 32'h50, 32'h0, 32'h0, 5'd2);
    dmem_ready = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    step();

    // Randomised instruction stream
    for (int op = 0; op < 200; op++) begin
      int kind, waits;
      kind  = $urandom_range(0, 9);
      waits = $urandom_range(0, 5);
      set_op(kind inside {1, 2, 3, 9}, kind inside {4, 5, 9}, 1'($urandom), 2'($urandom),
             $urandom, $urandom, $urandom, 5'($urandom));
      for (int c = 0; c < 10; c++) begin
        dmem_rdata = $urandom;
        dmem_ready = (memreadM | memwriteM) ? (c == waits) : 1'($urandom);
        step();
        if (!m_last_stall) break;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
